// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// Parametrised universal shift register with a built-in serialiser sequencer.
// Manual modes: shift right/left, rotate right/left, parallel load and clear.
// The sequencer loads a word and shifts it out over exactly WIDTH cycles.
// It then pulses done for one cycle. Reset is synchronous and active-high.

module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic             s_out,
    output logic [WIDTH-1:0] Q
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROTR  = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;

    // Candidate next values for every single-place move of the register.
    logic [WIDTH-1:0] w_shr_next;
    logic [WIDTH-1:0] w_shl_next;
    logic [WIDTH-1:0] w_rotr_next;
    logic [WIDTH-1:0] w_rotl_next;
    logic [WIDTH-1:0] w_man_next;
    logic [WIDTH-1:0] w_seq_next;
    logic             w_act_dir;

    // Build the shift and rotate results one bit at a time.
    // The end bits take either s_in or the wrapped-around bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bits
            if (gi == WIDTH - 1) begin : g_msb
                assign w_shr_next[gi]  = s_in;
                assign w_rotr_next[gi] = r_q[0];
            end else begin : g_not_msb
                assign w_shr_next[gi]  = r_q[gi + 1];
                assign w_rotr_next[gi] = r_q[gi + 1];
            end

            if (gi == 0) begin : g_lsb
                assign w_shl_next[gi]  = s_in;
                assign w_rotl_next[gi] = r_q[WIDTH - 1];
            end else begin : g_not_lsb
                assign w_shl_next[gi]  = r_q[gi - 1];
                assign w_rotl_next[gi] = r_q[gi - 1];
            end
        end
    endgenerate

    // Manual-mode next value. Codes 000 and 111 both hold the register.
    always_comb begin
        w_man_next = r_q;
        case (mode)
            MODE_HOLD:  w_man_next = r_q;
            MODE_SHR:   w_man_next = w_shr_next;
            MODE_SHL:   w_man_next = w_shl_next;
            MODE_ROTR:  w_man_next = w_rotr_next;
            MODE_ROTL:  w_man_next = w_rotl_next;
            MODE_LOAD:  w_man_next = p_in;
            MODE_CLEAR: w_man_next = '0;
            default:    w_man_next = r_q;
        endcase
    end

    // The sequencer only ever shifts. It never rotates, so s_in fills the vacated end.
    assign w_seq_next = r_dir ? w_shl_next : w_shr_next;

    // Single FSM: reset wins, then the sequencer, then the manual mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= RST_VAL;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q     <= p_in;
                        r_dir   <= dir;
                        r_cnt   <= CW'(WIDTH);
                        r_state <= S_SHIFT;
                    end else begin
                        r_q <= w_man_next;
                    end
                end
                S_SHIFT: begin
                    r_q   <= w_seq_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Q holds here. A start seen in this state is dropped rather than queued.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status flags are decoded straight from the registered state.
    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

    // Select the active direction.
    // While the sequencer owns the register, the latched direction is used.
    // Otherwise the direction implied by the manual mode is used.
    assign w_act_dir = (r_state != S_IDLE) ? r_dir
                                           : ((mode == MODE_SHL) || (mode == MODE_ROTL));

    assign s_out = w_act_dir ? r_q[WIDTH - 1] : r_q[0];
    assign Q     = r_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg.
// It runs an 8-bit instance with RST_VAL=0 and a 16-bit instance with RST_VAL=16'h5A5A.

module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        rst8, s_in8, start8, dir8, busy8, done8, sout8;
    logic [2:0]  mode8;
    logic [7:0]  p8, q8;

    // 16-bit instance
    logic        rst16, s_in16, start16, dir16, busy16, done16, sout16;
    logic [2:0]  mode16;
    logic [15:0] p16, q16;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
        .clk(clk), .rst(rst8), .mode(mode8), .s_in(s_in8), .p_in(p8),
        .start(start8), .dir(dir8), .busy(busy8), .done(done8),
        .s_out(sout8), .Q(q8)
    );

    univ_shift_reg #(.WIDTH(16), .RST_VAL(16'h5A5A)) dut16 (
        .clk(clk), .rst(rst16), .mode(mode16), .s_in(s_in16), .p_in(p16),
        .start(start16), .dir(dir16), .busy(busy16), .done(done16),
        .s_out(sout16), .Q(q16)
    );

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_of(input bit w16);
        return w16 ? {16'h0, q16} : {24'h0, q8};
    endfunction
    function automatic logic sout_of(input bit w16);
        return w16 ? sout16 : sout8;
    endfunction
    function automatic logic busy_of(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction
    function automatic logic done_of(input bit w16);
        return w16 ? done16 : done8;
    endfunction

    task automatic drive(input bit w16, input logic st, input logic d, input logic [31:0] p);
        if (w16) begin
            start16 = st; dir16 = d; p16 = p[15:0];
        end else begin
            start8 = st; dir8 = d; p8 = p[7:0];
        end
    endtask

    task automatic set_rst(input bit w16, input logic v);
        if (w16) rst16 = v; else rst8 = v;
    endtask

    // Full sequence with s_in=0.
    // Check each serial bit, that busy lasts n cycles, the single done pulse and the final Q.
    task automatic run_seq(input bit w16, input logic d, input logic [31:0] p, input int n);
        int bidx;
        drive(w16, 1'b1, d, p);
        tick;
        drive(w16, 1'b0, ~d, 32'h0);
        for (int i = 0; i < n; i++) begin
            bidx = d ? (n - 1 - i) : i;
            chk($sformatf("seq_w%0d_d%0d_sout%0d", n, d, i), {31'h0, sout_of(w16)}, {31'h0, p[bidx]});
            chk($sformatf("seq_w%0d_d%0d_busy%0d", n, d, i), {31'h0, busy_of(w16)}, 32'h1);
            chk($sformatf("seq_w%0d_d%0d_done%0d", n, d, i), {31'h0, done_of(w16)}, 32'h0);
            tick;
        end
        chk($sformatf("seq_w%0d_done_pulse", n), {31'h0, done_of(w16)}, 32'h1);
        chk($sformatf("seq_w%0d_busy_end", n), {31'h0, busy_of(w16)}, 32'h0);
        chk($sformatf("seq_w%0d_q_end", n), q_of(w16), 32'h0);
        tick;
        chk($sformatf("seq_w%0d_done_once", n), {31'h0, done_of(w16)}, 32'h0);
        chk($sformatf("seq_w%0d_idle", n), {31'h0, busy_of(w16)}, 32'h0);
    endtask

    // Reset on the 4th shift edge must abort the sequence without a done pulse.
    // A start on the very next cycle must then run normally.
    task automatic run_abort(input bit w16, input logic [31:0] p, input logic [31:0] rv, input int n);
        drive(w16, 1'b1, 1'b0, p);
        tick;
        drive(w16, 1'b0, 1'b0, p);
        tick; tick; tick;
        set_rst(w16, 1'b1);
        tick;
        chk($sformatf("abort_w%0d_q_rst", n), q_of(w16), rv);
        chk($sformatf("abort_w%0d_busy_rst", n), {31'h0, busy_of(w16)}, 32'h0);
        chk($sformatf("abort_w%0d_done_rst", n), {31'h0, done_of(w16)}, 32'h0);
        set_rst(w16, 1'b0);
        drive(w16, 1'b1, 1'b0, p);
        tick;
        drive(w16, 1'b0, 1'b0, 32'h0);
        chk($sformatf("abort_w%0d_restart_q", n), q_of(w16), p);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("abort_w%0d_busy%0d", n, i), {31'h0, busy_of(w16)}, 32'h1);
            chk($sformatf("abort_w%0d_done%0d", n, i), {31'h0, done_of(w16)}, 32'h0);
            tick;
        end
        chk($sformatf("abort_w%0d_done_pulse", n), {31'h0, done_of(w16)}, 32'h1);
        chk($sformatf("abort_w%0d_q_end", n), q_of(w16), 32'h0);
        tick;
        chk($sformatf("abort_w%0d_done_once", n), {31'h0, done_of(w16)}, 32'h0);
    endtask

    initial begin
        logic [7:0] v81;
        rst8 = 1'b1; s_in8 = 1'b0; start8 = 1'b0; dir8 = 1'b0; mode8 = 3'b000; p8 = 8'h00;
        rst16 = 1'b1; s_in16 = 1'b0; start16 = 1'b0; dir16 = 1'b0; mode16 = 3'b000; p16 = 16'h0000;

        // Reset for 2 cycles
        tick; tick;
        chk("rst_q8", {24'h0, q8}, 32'h00);
        chk("rst_busy8", {31'h0, busy8}, 32'h0);
        chk("rst_done8", {31'h0, done8}, 32'h0);
        chk("rst_q16", {16'h0, q16}, 32'h5A5A);
        chk("rst_busy16", {31'h0, busy16}, 32'h0);
        rst8 = 1'b0; rst16 = 1'b0;

        // Load, then hold
        mode8 = 3'b101; p8 = 8'hA5; tick;
        chk("load_A5", {24'h0, q8}, 32'hA5);
        mode8 = 3'b000; p8 = 8'h00; tick;
        chk("hold_A5", {24'h0, q8}, 32'hA5);

        // Shift right with s_in=1 three times, then rotate right and rotate left
        mode8 = 3'b001; s_in8 = 1'b1;
        tick; chk("shr1", {24'h0, q8}, 32'hD2);
        tick; chk("shr2", {24'h0, q8}, 32'hE9);
        tick; chk("shr3", {24'h0, q8}, 32'hF4);
        mode8 = 3'b011; tick; chk("rotr", {24'h0, q8}, 32'h7A);
        mode8 = 3'b100; tick; chk("rotl", {24'h0, q8}, 32'hF4);

        // s_out in IDLE follows the mode direction (Q=F4: msb 1, lsb 0)
        s_in8 = 1'b0;
        mode8 = 3'b010; #1; chk("idle_sout_shl", {31'h0, sout8}, 32'h1);
        mode8 = 3'b001; #1; chk("idle_sout_shr", {31'h0, sout8}, 32'h0);
        mode8 = 3'b010; tick; chk("shl0", {24'h0, q8}, 32'hE8);
        mode8 = 3'b111; tick; chk("hold111", {24'h0, q8}, 32'hE8);
        mode8 = 3'b110; tick; chk("clear", {24'h0, q8}, 32'h00);

        // Right-first serialisation of C3. Clear is applied on the start edge, where it must be ignored.
        run_seq(1'b0, 1'b0, 32'hC3, 8);
        mode8 = 3'b000;

        // Left-first serialisation of 81.
        // A second start in cycle 3 and a clear from cycle 4 must both be ignored.
        v81 = 8'h81;
        drive(1'b0, 1'b1, 1'b1, 32'h81);
        tick;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) start8 = 1'b1;
            if (i == 3) begin start8 = 1'b0; mode8 = 3'b110; end
            if (i == 4) chk("seq81_q_mid", {24'h0, q8}, 32'h10);
            chk($sformatf("seq81_sout%0d", i), {31'h0, sout8}, {31'h0, v81[7 - i]});
            chk($sformatf("seq81_busy%0d", i), {31'h0, busy8}, 32'h1);
            chk($sformatf("seq81_done%0d", i), {31'h0, done8}, 32'h0);
            tick;
        end
        chk("seq81_done_pulse", {31'h0, done8}, 32'h1);
        mode8 = 3'b000;
        tick;
        chk("seq81_no_restart", {31'h0, busy8}, 32'h0);
        chk("seq81_done_once", {31'h0, done8}, 32'h0);

        // Reset during a running sequence
        run_abort(1'b0, 32'hC3, 32'h00, 8);

        // 16-bit variant
        run_seq(1'b1, 1'b0, 32'h8001, 16);
        run_seq(1'b1, 1'b1, 32'h8001, 16);
        run_abort(1'b1, 32'h8001, 32'h5A5A, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
